// File: rtl/sft_seq.sv
// -----------------------------------------------------------------------------
// sft_seq -- command sequencer for one 74HC595-style shift-register chain driver
//
// A single start request (up to 4 data bytes) is expanded into the full command
// train for the shift unit:
//   [MR if clr_first], SHIFT byte nbytes-1 .. byte 0, STORE latch, OE update.
// Every command is strobed for one cycle on sft_vld; the sequencer then waits
// for the shift unit's sft_done pulse (bounded by TIMEOUT cycles) before
// issuing the next one.
//
// Ports
//   CLK_I        in   1   system clock
//   RST_I        in   1   synchronous, active-high reset
//   start        in   1   one-cycle request, sampled only while idle
//   clr_first    in   1   with start: issue master reset step first
//   nbytes       in   3   with start: byte count, legal 1..4
//   data         in   32  with start: byte k = data[8k+7:8k]
//   oe_en        in   1   with start: final output-enable level
//   busy         out  1   sequence in progress
//   done         out  1   one-cycle pulse: sequence completed
//   err          out  1   one-cycle pulse: illegal nbytes or step timeout
//   sft_vld      out  1   one-cycle command strobe to the shift unit
//   sft_cmd      out  2   00 MR, 01 shift byte, 10 storage latch, 11 OE update
//   sft_cmd_oen  out  1   oe_n level carried with the OE update (= ~oe_en)
//   sft_din      out  8   byte for the shift command, 0 otherwise
//   sft_done     in   1   shift unit step-complete pulse
// -----------------------------------------------------------------------------
module sft_seq #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        start,
    input  logic        clr_first,
    input  logic [2:0]  nbytes,
    input  logic [31:0] data,
    input  logic        oe_en,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        sft_vld,
    output logic [1:0]  sft_cmd,
    output logic        sft_cmd_oen,
    output logic [7:0]  sft_din,
    input  logic        sft_done
);

    localparam logic [1:0] CMD_MR    = 2'b00;
    localparam logic [1:0] CMD_SHIFT = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;
    localparam logic [1:0] CMD_OE    = 2'b11;

    // The abort decision is taken on the WAIT cycle whose increment would
    // bring the timer to TIMEOUT-1, so the compare is against TIMEOUT-2.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 2);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_FIN   = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [2:0]      ptr_r, ptr_s;
    logic [TO_W-1:0] timer_r, timer_s;
    logic            clr_r, clr_s;
    logic [2:0]      nbytes_r, nbytes_s;
    logic [31:0]     data_r, data_s;
    logic            oe_en_r, oe_en_s;

    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            err_r, err_s;
    logic            vld_r, vld_s;
    logic [1:0]      cmd_r, cmd_s;
    logic            oen_r, oen_s;
    logic [7:0]      din_r, din_s;

    logic            illegal_s;
    logic            legal_s;
    logic [2:0]      last_s;
    logic [10:0]     step_s;

    // Decode step index ptr of a latched request into {cmd, oen, din}.
    function automatic logic [10:0] decode_step(
        input logic [2:0]  ptr,
        input logic        clr,
        input logic [2:0]  nb,
        input logic [31:0] dat,
        input logic        oe
    );
        logic [2:0] k;
        logic [1:0] bsel;
        logic [1:0] cmd;
        logic [7:0] din;
        k    = ptr - {2'b00, clr};
        bsel = 2'b00;
        cmd  = CMD_MR;
        din  = 8'h00;
        if (clr && (ptr == 3'd0)) begin
            cmd = CMD_MR;
        end else if (k < nb) begin
            // highest byte goes out first
            cmd  = CMD_SHIFT;
            bsel = 2'(nb - 3'd1 - k);
            case (bsel)
                2'd0:    din = dat[7:0];
                2'd1:    din = dat[15:8];
                2'd2:    din = dat[23:16];
                2'd3:    din = dat[31:24];
                default: din = 8'h00;
            endcase
        end else if (k == nb) begin
            cmd = CMD_STORE;
        end else begin
            cmd = CMD_OE;
        end
        return {cmd, ~oe, din};
    endfunction

    assign legal_s = (nbytes != 3'd0) && (nbytes <= 3'd4);
    // index of the final (OE) step of the latched request
    assign last_s  = nbytes_r + 3'd1 + {2'b00, clr_r};

    // Next-state, request latch, timer and next output values.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        timer_s   = timer_r;
        clr_s     = clr_r;
        nbytes_s  = nbytes_r;
        data_s    = data_r;
        oe_en_s   = oe_en_r;
        illegal_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (legal_s) begin
                        clr_s    = clr_first;
                        nbytes_s = nbytes;
                        data_s   = data;
                        oe_en_s  = oe_en;
                        ptr_s    = 3'd0;
                        state_s  = ST_ISSUE;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                timer_s = {TO_W{1'b0}};
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (sft_done) begin
                    if (ptr_r == last_s) begin
                        state_s = ST_FIN;
                    end else begin
                        ptr_s   = ptr_r + 3'd1;
                        state_s = ST_ISSUE;
                    end
                end else if (timer_r >= TO_LAST) begin
                    state_s = ST_ABORT;
                end else begin
                    if (timer_r != TO_MAX) begin
                        timer_s = timer_r + TO_W'(1);
                    end else begin
                        timer_s = timer_r;
                    end
                end
            end
            ST_FIN:   state_s = ST_IDLE;
            ST_ABORT: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase

        busy_s = (state_s == ST_ISSUE) || (state_s == ST_WAIT);
        done_s = (state_s == ST_FIN);
        err_s  = illegal_s || (state_s == ST_ABORT);
        vld_s  = (state_s == ST_ISSUE);
        step_s = decode_step(ptr_s, clr_s, nbytes_s, data_s, oe_en_s);

        // command fields only change when a new command is strobed
        if (vld_s) begin
            cmd_s = step_s[10:9];
            oen_s = step_s[8];
            din_s = step_s[7:0];
        end else begin
            cmd_s = cmd_r;
            oen_s = oen_r;
            din_s = din_r;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r  <= ST_IDLE;
            ptr_r    <= 3'd0;
            timer_r  <= {TO_W{1'b0}};
            clr_r    <= 1'b0;
            nbytes_r <= 3'd0;
            data_r   <= 32'h0000_0000;
            oe_en_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            vld_r    <= 1'b0;
            cmd_r    <= 2'b00;
            oen_r    <= 1'b0;
            din_r    <= 8'h00;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            timer_r  <= timer_s;
            clr_r    <= clr_s;
            nbytes_r <= nbytes_s;
            data_r   <= data_s;
            oe_en_r  <= oe_en_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            err_r    <= err_s;
            vld_r    <= vld_s;
            cmd_r    <= cmd_s;
            oen_r    <= oen_s;
            din_r    <= din_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign sft_vld     = vld_r;
    assign sft_cmd     = cmd_r;
    assign sft_cmd_oen = oen_r;
    assign sft_din     = din_r;

endmodule

// File: tb/tb_sft_seq.sv
// -----------------------------------------------------------------------------
// tb_sft_seq -- self-checking bench for sft_seq.
// A cycle-numbered reference model (queue of expected commands plus the cycle
// of the last strobe) predicts every output each cycle; a responder plays the
// shift unit. Directed scenarios pin the model with literal expectations, then
// a randomized phase exercises timeouts, stale/stray sft_done, ignored starts
// and mid-sequence reset.
// -----------------------------------------------------------------------------
module tb_sft_seq;

    localparam int TIMEOUT = 8;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        start = 1'b0;
    logic        clr_first = 1'b0;
    logic [2:0]  nbytes = 3'd0;
    logic [31:0] data = 32'h0;
    logic        oe_en = 1'b0;
    logic        sft_done = 1'b0;
    logic        busy, done, err, sft_vld, sft_cmd_oen;
    logic [1:0]  sft_cmd;
    logic [7:0]  sft_din;

    always #5 CLK_I = ~CLK_I;

    sft_seq #(.TO_W(16), .TIMEOUT(TIMEOUT)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .clr_first(clr_first),
        .nbytes(nbytes), .data(data), .oe_en(oe_en), .busy(busy), .done(done),
        .err(err), .sft_vld(sft_vld), .sft_cmd(sft_cmd), .sft_cmd_oen(sft_cmd_oen),
        .sft_din(sft_din), .sft_done(sft_done)
    );

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] din;
        logic       oen;
    } step_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model
    step_t m_steps[$];
    bit    m_active = 1'b0;
    int    m_vld_cyc = 0;
    int    m_free = 0;
    logic  e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_vld = 1'b0, e_oen = 1'b0;
    logic [1:0] e_cmd = 2'b00;
    logic [7:0] e_din = 8'h00;

    // responder and logs
    bit    rand_mode = 1'b0;
    int    resp_delay = 3;
    int    resp_never_from = 0;
    bit    resp_stale = 1'b0;
    int    stray_pct = 0;
    int    pend_cyc = -1;
    int    stale_cyc = -1;
    step_t vlog[$];
    int    vld_cnt = 0, done_cnt = 0, err_cnt = 0;
    int    first_vld_cyc = 0, last_vld_cyc = 0, err_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic issue_next(input int c);
        step_t s;
        s = m_steps.pop_front();
        e_vld     = 1'b1;
        e_cmd     = s.cmd;
        e_din     = s.din;
        e_oen     = s.oen;
        m_vld_cyc = c;
    endtask

    // Given the inputs of cycle k, predict the outputs of cycle k+1.
    task automatic model_step(input int k, input bit rst, input bit st, input bit clr,
                              input logic [2:0] nb, input logic [31:0] d, input bit oe,
                              input bit dn);
        step_t s;
        if (rst) begin
            m_steps.delete();
            m_active = 1'b0;
            m_free = k + 1;
            {e_busy, e_done, e_err, e_vld, e_oen} = 5'b0;
            e_cmd = 2'b00;
            e_din = 8'h00;
            return;
        end
        e_vld = 1'b0; e_done = 1'b0; e_err = 1'b0;
        if (!m_active) begin
            e_busy = 1'b0;
            if (st && k >= m_free) begin
                if (nb >= 3'd1 && nb <= 3'd4) begin
                    m_steps.delete();
                    if (clr) begin
                        s = '{cmd: 2'b00, din: 8'h00, oen: ~oe};
                        m_steps.push_back(s);
                    end
                    for (int b = int'(nb) - 1; b >= 0; b--) begin
                        s = '{cmd: 2'b01, din: d[8*b +: 8], oen: ~oe};
                        m_steps.push_back(s);
                    end
                    s = '{cmd: 2'b10, din: 8'h00, oen: ~oe};
                    m_steps.push_back(s);
                    s = '{cmd: 2'b11, din: 8'h00, oen: ~oe};
                    m_steps.push_back(s);
                    m_active = 1'b1;
                    e_busy = 1'b1;
                    issue_next(k + 1);
                end else begin
                    e_err = 1'b1;
                end
            end
        end else if (k == m_vld_cyc) begin
            e_busy = 1'b1;                       // strobe cycle: sft_done is stale
        end else if (dn) begin
            if (m_steps.size() > 0) begin
                e_busy = 1'b1;
                issue_next(k + 1);
            end else begin
                e_busy = 1'b0; e_done = 1'b1; m_active = 1'b0; m_free = k + 2;
            end
        end else if (k - m_vld_cyc >= TIMEOUT - 1) begin
            e_busy = 1'b0; e_err = 1'b1; m_active = 1'b0; m_free = k + 2;
        end else begin
            e_busy = 1'b1;
        end
    endtask

    // One clock: drive inputs for cycle cyc, predict, compare at the next negedge.
    task automatic tick();
        bit    dn;
        bit    r;
        int    d;
        step_t s;
        dn = (cyc == pend_cyc) || (cyc == stale_cyc) ||
             (stray_pct > 0 && int'($urandom_range(0, 99)) < stray_pct);
        sft_done = dn;
        r = RST_I;
        model_step(cyc, r, start, clr_first, nbytes, data, oe_en, dn);
        @(negedge CLK_I);
        cyc++;
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("err", err, e_err);
        check("sft_vld", sft_vld, e_vld);
        check("sft_cmd", sft_cmd, e_cmd);
        check("sft_din", sft_din, e_din);
        if (e_cmd == 2'b11 || r) check("sft_cmd_oen", sft_cmd_oen, e_oen);
        if (sft_vld === 1'b1) begin
            s = {sft_cmd, sft_din, sft_cmd_oen};
            vlog.push_back(s);
            vld_cnt++;
            last_vld_cyc = cyc;
            if (vld_cnt == 1) first_vld_cyc = cyc;
            if (rand_mode) begin
                d = int'($urandom_range(1, 9));
                pend_cyc  = (d == 9) ? -1 : cyc + d;
                stale_cyc = ($urandom_range(0, 3) == 0) ? cyc : -1;
            end else begin
                pend_cyc  = (resp_never_from != 0 && vld_cnt >= resp_never_from) ? -1 : cyc + resp_delay;
                stale_cyc = resp_stale ? cyc : -1;
            end
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    endtask

    task automatic do_start(input bit clr, input logic [2:0] nb, input logic [31:0] d, input bit oe);
        start = 1'b1; clr_first = clr; nbytes = nb; data = d; oe_en = oe;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        RST_I = 1'b1;
        repeat (n) tick();
        RST_I = 1'b0;
        pend_cyc = -1;
        stale_cyc = -1;
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((m_active || cyc < m_free) && n < max) begin
            tick();
            n++;
        end
        n_checks++;
        if (m_active || cyc < m_free) begin
            n_fail++;
            $display("FAIL run_idle at cycle %0d: sequence still active after %0d cycles", cyc, max);
        end
        tick();
    endtask

    task automatic clr_log();
        vlog.delete();
        vld_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    initial begin
        int t_start;
        int gap;
        logic [2:0] nb;

        do_reset(3);
        check("rst_busy", busy, 1'b0);
        check("rst_vld", sft_vld, 1'b0);

        // T1: MR, two bytes, store, OE with oe_en=1
        clr_log(); resp_delay = 3;
        t_start = cyc;
        do_start(1'b1, 3'd2, 32'h0000_A55A, 1'b1);
        run_idle(200);
        check("t1_latency", first_vld_cyc - t_start, 1);
        check("t1_nvld", vlog.size(), 5);
        check("t1_done_cnt", done_cnt, 1);
        if (vlog.size() == 5) begin
            check("t1_s0", {vlog[0].cmd, vlog[0].din}, {2'b00, 8'h00});
            check("t1_s1", {vlog[1].cmd, vlog[1].din}, {2'b01, 8'hA5});
            check("t1_s2", {vlog[2].cmd, vlog[2].din}, {2'b01, 8'h5A});
            check("t1_s3", {vlog[3].cmd, vlog[3].din}, {2'b10, 8'h00});
            check("t1_s4", {vlog[4].cmd, vlog[4].oen}, {2'b11, 1'b0});
        end

        // T2: four bytes, highest first, no MR
        clr_log(); resp_delay = 1;
        do_start(1'b0, 3'd4, 32'h1122_3344, 1'b0);
        run_idle(200);
        check("t2_nvld", vlog.size(), 6);
        if (vlog.size() == 6) begin
            check("t2_b0", {vlog[0].cmd, vlog[0].din}, {2'b01, 8'h11});
            check("t2_b1", {vlog[1].cmd, vlog[1].din}, {2'b01, 8'h22});
            check("t2_b2", {vlog[2].cmd, vlog[2].din}, {2'b01, 8'h33});
            check("t2_b3", {vlog[3].cmd, vlog[3].din}, {2'b01, 8'h44});
            check("t2_st", vlog[4].cmd, 2'b10);
            check("t2_oe", {vlog[5].cmd, vlog[5].oen}, {2'b11, 1'b1});
        end

        // T3: illegal byte counts, with stray sft_done while idle
        clr_log(); stray_pct = 30;
        do_start(1'b0, 3'd0, 32'hDEAD_BEEF, 1'b1);
        do_start(1'b1, 3'd5, 32'hDEAD_BEEF, 1'b1);
        repeat (4) tick();
        stray_pct = 0;
        check("t3_err_cnt", err_cnt, 2);
        check("t3_nvld", vld_cnt, 0);

        // T4: shift unit goes silent after the 2nd strobe
        clr_log(); resp_delay = 2; resp_never_from = 2;
        do_start(1'b0, 3'd2, 32'h0000_C3C3, 1'b1);
        run_idle(200);
        check("t4_err_delay", err_cyc - last_vld_cyc, TIMEOUT);
        check("t4_nvld", vld_cnt, 2);
        check("t4_err_cnt", err_cnt, 1);
        check("t4_done_cnt", done_cnt, 0);
        clr_log(); resp_never_from = 0;
        do_start(1'b0, 3'd1, 32'h0000_0077, 1'b1);
        run_idle(200);
        check("t4_recover_done", done_cnt, 1);
        check("t4_recover_nvld", vld_cnt, 3);

        // T5: start while busy is ignored; stale sft_done on every strobe cycle
        clr_log(); resp_delay = 2; resp_stale = 1'b1;
        do_start(1'b0, 3'd3, 32'hAABB_CCDD, 1'b0);
        repeat (3) tick();
        do_start(1'b1, 3'd4, 32'h0102_0304, 1'b1);
        run_idle(200);
        resp_stale = 1'b0;
        check("t5_nvld", vlog.size(), 5);
        if (vlog.size() == 5) begin
            check("t5_b0", vlog[0].din, 8'hBB);
            check("t5_b1", vlog[1].din, 8'hCC);
            check("t5_b2", vlog[2].din, 8'hDD);
            check("t5_oe", {vlog[4].cmd, vlog[4].oen}, {2'b11, 1'b1});
        end

        // T6: reset in WAIT of step 3
        clr_log(); resp_delay = 4;
        do_start(1'b1, 3'd3, 32'h0055_66AA, 1'b1);
        for (int n = 0; n < 100 && vld_cnt < 3; n++) tick();
        check("t6_reached_step3", vld_cnt, 3);
        tick();
        do_reset(1);
        check("t6_busy", busy, 1'b0);
        check("t6_cmd", sft_cmd, 2'b00);
        repeat (10) tick();
        check("t6_no_done", done_cnt, 0);
        check("t6_no_err", err_cnt, 0);
        check("t6_no_vld", vld_cnt, 3);
        clr_log();
        do_start(1'b0, 3'd2, 32'h0000_1234, 1'b0);
        run_idle(200);
        check("t6_post_done", done_cnt, 1);

        // randomized phase
        rand_mode = 1'b1; stray_pct = 4;
        for (int it = 0; it < 60; it++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) tick();
            nb = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) nb = 3'($urandom_range(1, 4));
            do_start(1'($urandom_range(0, 1)), nb, $urandom, 1'($urandom_range(0, 1)));
            for (int n = 0; n < 150 && (m_active || cyc < m_free); n++) begin
                if ($urandom_range(0, 9) == 0) begin
                    start = 1'b1; nbytes = 3'($urandom_range(0, 7)); data = $urandom;
                    clr_first = 1'($urandom_range(0, 1)); oe_en = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 199) == 0) begin
                    start = 1'b0;
                    do_reset(1);
                end else begin
                    tick();
                    start = 1'b0;
                end
            end
        end
        rand_mode = 1'b0; stray_pct = 0;
        run_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
